flag_condition_unit: RTL
========================

Name: flag_condition_unit

Overview:
- Consumer side of the ALU status flags. Latches the NZCV flags produced by the ALU flag logic into a status register.
- Evaluates 4-bit branch/condition codes against the latched flags and returns a registered taken/not-taken result over a valid/ready handshake.
- Provides a small LIFO of saved flag contexts for interrupt entry and exit.
- Sits between the ALU and the control/sequencer logic.

Parameters:
- STACK_DEPTH, 4, number of saved NZCV entries in the context stack (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flags_we  in  1  load flags_in into the status register this cycle.
- flags_in  in  4  {Negative, Zero, Carry, Overflow} from the ALU flag logic.
- cond_valid  in  1  condition-evaluation request valid.
- cond_code  in  4  condition code to evaluate.
- cond_ready  out  1  unit can accept a request this cycle.
- result_valid  out  1  result_taken is valid.
- result_taken  out  1  1 = condition true.
- result_ready  in  1  downstream accepts the result.
- push  in  1  save current flags_q onto the context stack.
- pop  in  1  restore flags_q from the stack top.
- flags_q  out  4  current latched {N,Z,C,V}.
- stack_full  out  1  stack holds STACK_DEPTH entries.
- stack_empty  out  1  stack holds 0 entries.
- err  out  1  sticky misuse flag.
- err_clr  in  1  clear err.

Behaviour:
- Reset (async, rst_n=0): flags_q=0, stack count=0 (stack_empty=1, stack_full=0), result_valid=0, result_taken=0, err=0. Stack contents are don't-care. Outputs reach these values immediately, without waiting for a clock edge.
- Carry convention: C as delivered by the ALU. For subtraction, C=1 means no borrow.
- Condition table, evaluated on flags_q:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: 0
- Handshake:
  - cond_ready = !result_valid | result_ready (combinational).
  - Accept when cond_valid & cond_ready. On the next edge, result_valid=1 and result_taken=eval(cond_code, flags_q as sampled at the accepting edge, i.e. pre-update value if flags_we is active in the same cycle).
  - Latency: 1 cycle. Throughput: 1 per cycle when result_ready is held at 1.
  - result_valid falls on the edge where result_ready=1 and no new request is accepted.
  - result_taken holds its value while result_valid=1 and result_ready=0.
- Status register update priority, per edge:
  - Valid pop (stack not empty, push=0): flags_q ← stack top, count−1. A flags_we in the same cycle is discarded.
  - Otherwise, if flags_we: flags_q ← flags_in.
- Push:
  - Valid push (not full, pop=0): stack[count] ← flags_q (pre-update value), count+1. A concurrent flags_we still updates flags_q.
- Error conditions: err ← 1 (sticky) on any of the following; in each case stack and flags_q are otherwise unaffected, except that flags_we still applies when no pop is performed.
  - push while full: push ignored.
  - pop while empty: pop ignored.
  - push & pop together: both ignored.
- err_clr: clears err on the next edge. A new error event in the same cycle wins (err stays 1).
- Boundaries:
  - count saturates at 0 and STACK_DEPTH; no wrap-around.
  - Reset mid-handshake drops any pending result (result_valid=0).

Test Plan:
- Reset, then flags_we=1, flags_in=4'b0100 (Z=1); next cycle request cond_code=0 (EQ) with result_ready=1 → one cycle later result_valid=1, result_taken=1. cond_code=1 (NE) → taken=0.
- Sweep all 16 codes over all 16 flag values → result_taken matches the condition table exactly (256 checks). Spot checks: flags 4'b1000 GE→0, LT→1; flags 4'b0010 HI→1; code F→0 always.
- Backpressure: result_ready=0, two requests → first accepted, cond_ready=0, result held stable. Raise result_ready → second accepted the same cycle, result delivered on the next edge.
- Stack: push 4 times with flags 1,2,3,4 → stack_full=1. 5th push → err=1, count stays 4. Four pops → flags_q=4,3,2,1 in order, stack_empty=1. 5th pop → flags_q unchanged at 1. err_clr → err=0.
- Same-cycle events: flags_we=1 (flags_in=9) with request code 0 while flags_q=4 → taken=1 (old flags), flags_q=9 afterwards. pop with flags_we → flags_q=stack top, flags_in discarded. push & pop together → err=1, count unchanged.
- Assert rst_n low while result_valid=1, count=2 → result_valid=0, flags_q=0, stack_empty=1 before the next clock edge.

Source files
------------

// File: rtl/flag_condition_unit.sv
// Purpose : latches ALU NZCV flags, evaluates condition codes on them, keeps a LIFO of saved flag contexts.
// Latency : 1 cycle from accepted request to result_valid/result_taken.
// Backpres: cond_ready = !result_valid | result_ready; a held result stays stable until result_ready.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   flags_we, flags_in[3:0]        load {N,Z,C,V} into the status register
//   cond_valid, cond_code, cond_ready          condition request handshake
//   result_valid, result_taken, result_ready   registered result handshake
//   push, pop                      save / restore flags_q via the context stack
//   flags_q[3:0]                   current latched {N,Z,C,V}
//   stack_full, stack_empty        context stack occupancy
//   err, err_clr                   sticky misuse flag and its clear
module flag_condition_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flags_we,
  input  logic [3:0] flags_in,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       result_valid,
  output logic       result_taken,
  input  logic       result_ready,
  input  logic       push,
  input  logic       pop,
  output logic [3:0] flags_q,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       err,
  input  logic       err_clr
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    stack_mem [STACK_DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] top_idx;
  logic          accept;
  logic          push_ok;
  logic          pop_ok;
  logic          err_evt;
  logic          cond_true;

  // flags are packed {N,Z,C,V}; C is the ALU carry as delivered (1 = no borrow on subtract)
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = !z;
      4'h2:    eval_cond = c;
      4'h3:    eval_cond = !c;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = !n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = !v;
      4'h8:    eval_cond = c & !z;
      4'h9:    eval_cond = !c | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = !z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  assign stack_full  = (count == CW'(STACK_DEPTH));
  assign stack_empty = (count == '0);
  assign top_idx     = count - CW'(1);

  assign cond_ready = !result_valid | result_ready;
  assign accept     = cond_valid & cond_ready;
  assign cond_true  = eval_cond(cond_code, flags_q);

  // simultaneous push and pop is treated as misuse: neither takes effect
  assign push_ok = push & !pop & !stack_full;
  assign pop_ok  = pop & !push & !stack_empty;
  assign err_evt = (push & pop) | (push & !pop & stack_full) | (pop & !push & stack_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= 4'h0;
      count        <= '0;
      result_valid <= 1'b0;
      result_taken <= 1'b0;
      err          <= 1'b0;
    end else begin
      // a restore from the stack overrides any ALU write in the same cycle
      if (pop_ok)
        flags_q <= stack_mem[top_idx[PW-1:0]];
      else if (flags_we)
        flags_q <= flags_in;

      if (push_ok)
        count <= count + CW'(1);
      else if (pop_ok)
        count <= count - CW'(1);

      // result_taken uses flags_q before any same-edge update
      if (accept) begin
        result_valid <= 1'b1;
        result_taken <= cond_true;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end

      // a fresh error event beats a concurrent clear
      if (err_evt)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

  // stack contents need no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push_ok)
      stack_mem[count[PW-1:0]] <= flags_q;
  end

endmodule
